input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Sits directly upstream of the game-logic block and produces its 5-bit `operation` command vector from raw push-buttons.
- Per button: synchronises, debounces and edge-detects the input.
- LEFT/RIGHT/DOWN get frame-based auto-repeat.
- Commands are accumulated and presented as a vector that is stable for one whole frame, so the consumer can sample it at the vsync falling edge.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clock cycles required before a debounced level changes (10 ms at 25 MHz).
- REPEAT_DELAY, 10: frames a repeatable button must be held before auto-repeat starts.
- REPEAT_RATE, 3: frames between auto-repeat events once repeating.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  5  raw asynchronous buttons; bit 0 RIGHT, 1 LEFT, 2 DOWN, 3 ROTATE, 4 START.
- vsync  input  1  frame sync, synchronous to clock; its rising edge is the frame tick.
- operation  output  5  command vector, same bit map as btn; held for one frame.
- btn_level  output  5  debounced button levels.

Behaviour:
- Reset: operation=0, btn_level=0, pending=0, all debounce counters=0, all repeat FSMs IDLE, vsync history register=0. A button held through reset must re-debounce after reset and counts as a new press.
- Synchroniser: 2-flop per btn bit.
- Debounce, per bit: counter increments while the synced bit differs from btn_level. On reaching DEBOUNCE_CYCLES-1 it toggles btn_level and clears. It clears whenever the synced bit equals btn_level. Counter width is $clog2(DEBOUNCE_CYCLES).
- Press event: btn_level 0->1, registered. Release generates no event.
- Frame tick: vsync=1 while the previous registered vsync=0. Exactly one cycle per frame.
- Repeat FSM, per bit 0..2:
  - IDLE: press -> emit event, frame_cnt=0, go DELAY.
  - DELAY: count frame ticks; on frame_cnt==REPEAT_DELAY-1 -> emit event, frame_cnt=0, go REPEAT.
  - REPEAT: on frame_cnt==REPEAT_RATE-1 -> emit event, frame_cnt=0.
  - Any state: btn_level=0 -> IDLE same cycle, no event.
  - frame_cnt is 4 bits, saturating.
- ROTATE and START: one event per press only, no repeat.
- Events OR into pending[4:0]. Multiple events of the same bit within one frame collapse to one.
- Frame transfer, on the frame tick cycle: operation <= pending | events_this_cycle; pending <= 0. operation is therefore valid from the cycle after vsync rises and is held constant until the next tick.
- Conflict: if the transferred vector has both RIGHT and LEFT set, both are cleared. DOWN, ROTATE and START are unaffected.
- With no events in a frame, operation becomes 0 at the next tick.
- Reset asserted mid-frame: operation drops to 0 the next cycle. Pending events are discarded.

Optional Feature:
- Macro: INPUT_START_LOCK_EN.
- Defined:
  - After reset the block is LOCKED.
  - While LOCKED, only bit 4 (START) may appear in operation; all other events are discarded before entering pending.
  - The first frame transfer carrying START sets UNLOCKED; START is delivered in that frame.
  - UNLOCKED persists until reset.
- Undefined: no lock state; all bits pass from reset.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2; vsync period 20 cycles):
- Bounce: btn[3] toggles 1,0,1 on three consecutive cycles, then holds 1 -> btn_level[3] rises exactly 4 stable cycles after the last toggle passes the synchroniser; exactly one frame shows operation=5'b01000; the next frame shows 0.
- Auto-repeat: hold btn[2] for 12 frames -> operation[2]=1 in the press frame, then 3 frames later, then every 2nd frame; release -> 0 from the next frame.
- Conflict: press btn[0] and btn[1] in the same frame -> operation=5'b00000. Press btn[1] alone the next frame -> 5'b00010.
- Frame boundary: a press event coinciding with the vsync rising cycle -> appears in the operation latched that cycle, not the following frame.
- Reset mid-operation: btn[0] repeating, assert reset 1 cycle -> operation=0 next cycle. With btn held, the next press event appears only after re-debounce (4 cycles plus sync latency).
- INPUT_START_LOCK_EN defined: press ROTATE then START in separate frames -> ROTATE frame operation=0, START frame operation=5'b10000; a subsequent ROTATE press -> 5'b01000.

Source files
------------

// File: rtl/input_conditioner.sv
// Button front end: sync, debounce, press detect, frame auto-repeat, frame-held commands.
// Optional START lock after reset: define INPUT_START_LOCK_EN.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic       vsync,
  output logic [4:0] operation,
  output logic [4:0] btn_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    RD_MAX = 4'(REPEAT_DELAY - 1);
  localparam logic [3:0]    RR_MAX = 4'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } rpt_state_t;

  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_level;
  logic [4:0]    r_press;
  logic [CW-1:0] r_db_cnt [5];
  logic          r_vsync_q;
  logic [4:0]    r_pending;
  logic [4:0]    r_operation;
  rpt_state_t    r_state [3];
  logic [3:0]    r_fcnt  [3];

  logic [4:0]    w_lvl_next;
  logic [CW-1:0] w_cnt_next [5];
  rpt_state_t    w_state_next [3];
  logic [3:0]    w_fcnt_next  [3];
  logic [2:0]    w_rpt_ev;
  logic [4:0]    w_ev;
  logic [4:0]    w_ev_in;
  logic [4:0]    w_xfer;
  logic [4:0]    w_xfer_ok;
  logic          w_tick;

  assign w_tick    = vsync & ~r_vsync_q;
  assign btn_level = r_level;
  assign operation = r_operation;

  always_comb begin
    w_lvl_next = r_level;
    for (int i = 0; i < 5; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_level[i]) begin
        if (r_db_cnt[i] == DB_MAX) begin
          w_lvl_next[i] = ~r_level[i];
        end else begin
          w_cnt_next[i] = r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Repeat next-state; a released button drops to IDLE without an event.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_state_next[i] = r_state[i];
      w_fcnt_next[i]  = r_fcnt[i];
      w_rpt_ev[i]     = 1'b0;
      if (!r_level[i]) begin
        w_state_next[i] = S_IDLE;
        w_fcnt_next[i]  = 4'd0;
      end else begin
        unique case (r_state[i])
          S_IDLE: begin
            if (r_press[i]) begin
              w_rpt_ev[i]     = 1'b1;
              w_fcnt_next[i]  = 4'd0;
              w_state_next[i] = S_DELAY;
            end
          end
          S_DELAY: begin
            if (w_tick) begin
              if (r_fcnt[i] == RD_MAX) begin
                w_rpt_ev[i]     = 1'b1;
                w_fcnt_next[i]  = 4'd0;
                w_state_next[i] = S_REPEAT;
              end else if (r_fcnt[i] != 4'hF) begin
                w_fcnt_next[i] = r_fcnt[i] + 4'd1;
              end
            end
          end
          S_REPEAT: begin
            if (w_tick) begin
              if (r_fcnt[i] == RR_MAX) begin
                w_rpt_ev[i]    = 1'b1;
                w_fcnt_next[i] = 4'd0;
              end else if (r_fcnt[i] != 4'hF) begin
                w_fcnt_next[i] = r_fcnt[i] + 4'd1;
              end
            end
          end
          default: begin
            w_state_next[i] = S_IDLE;
            w_fcnt_next[i]  = 4'd0;
          end
        endcase
      end
    end
  end

  assign w_ev = {r_press[4:3], w_rpt_ev};

`ifdef INPUT_START_LOCK_EN
  logic r_unlocked;
  assign w_ev_in = r_unlocked ? w_ev : (w_ev & 5'b10000);
`else
  assign w_ev_in = w_ev;
`endif

  // Opposing directions in one frame cancel each other.
  assign w_xfer = r_pending | w_ev_in;
  always_comb begin
    w_xfer_ok = w_xfer;
    if (w_xfer[0] && w_xfer[1]) begin
      w_xfer_ok[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_level     <= '0;
      r_press     <= '0;
      r_vsync_q   <= 1'b0;
      r_pending   <= '0;
      r_operation <= '0;
      for (int i = 0; i < 5; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_level   <= w_lvl_next;
      r_press   <= w_lvl_next & ~r_level;
      r_vsync_q <= vsync;
      for (int i = 0; i < 5; i++) begin
        r_db_cnt[i] <= w_cnt_next[i];
      end
      if (w_tick) begin
        r_operation <= w_xfer_ok;
        r_pending   <= '0;
      end else begin
        r_pending <= w_xfer;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= S_IDLE;
        r_fcnt[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= w_state_next[i];
        r_fcnt[i]  <= w_fcnt_next[i];
      end
    end
  end

`ifdef INPUT_START_LOCK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_unlocked <= 1'b0;
    end else if (w_tick && w_xfer_ok[4]) begin
      r_unlocked <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random buttons
// against a frame-level reference model.
module tb_input_conditioner;

  localparam int DB = 4;
  localparam int RD = 3;
  localparam int RR = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic       vsync;
  logic [4:0] operation;
  logic [4:0] btn_level;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn      (btn),
    .vsync    (vsync),
    .operation(operation),
    .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int vc     = 19;
  logic run_chk = 1'b0;

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic [4:0] b, input logic r);
    @(negedge clock);
    btn   = b;
    reset = r;
    vc    = (vc == 19) ? 0 : vc + 1;
    vsync = (vc < 2);
  endtask

  // Reference model: raw level after 2-cycle sync, level flips after DB
  // consecutive disagreeing samples, repeat from frames held since press.
  logic [4:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_pend, m_op;
  logic       m_vsq, m_unl;
  int         m_run  [5];
  int         m_held [3];

  always @(posedge clock) begin : model_b
    logic [4:0] ev, x, pr;
    logic tk;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0;
      m_pend = '0; m_op = '0; m_vsq = 1'b0; m_unl = 1'b0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;
      for (int b = 0; b < 3; b++) m_held[b] = -1;
    end else begin
      tk = vsync && !m_vsq;
      pr = m_lvl & ~m_lvl_prev;
      ev = '0;
      for (int b = 0; b < 3; b++) begin
        if (!m_lvl[b]) m_held[b] = -1;
        else if (pr[b]) begin
          ev[b] = 1'b1;
          m_held[b] = 0;
        end else if (m_held[b] >= 0 && tk) begin
          m_held[b]++;
          if (m_held[b] == RD ||
              (m_held[b] > RD && (m_held[b] - RD) % RR == 0))
            ev[b] = 1'b1;
        end
      end
      ev[3] = pr[3];
      ev[4] = pr[4];
`ifdef INPUT_START_LOCK_EN
      if (!m_unl) ev = ev & 5'b10000;
`endif
      if (tk) begin
        x = m_pend | ev;
        if (x[0] && x[1]) x[1:0] = 2'b00;
        m_op = x;
        m_pend = '0;
        if (x[4]) m_unl = 1'b1;
      end else begin
        m_pend = m_pend | ev;
      end
      m_lvl_prev = m_lvl;
      for (int b = 0; b < 5; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = ~m_lvl[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2  = m_s1;
      m_s1  = btn;
      m_vsq = vsync;
    end
  end

  always @(negedge clock) begin
    if (run_chk) begin
      chk("op", operation, m_op);
      chk("lvl", btn_level, m_lvl);
    end
  end

  initial begin
    logic [4:0] cur;
    btn = '0; reset = 1'b1; vsync = 1'b0;
    repeat (3) step(5'b0, 1'b1);
    run_chk = 1'b1;
    @(posedge clock); #1;
    chk("rst_op", operation, 5'b00000);
    chk("rst_lvl", btn_level, 5'b00000);
    step(5'b0, 1'b0);
    repeat (30) step(5'b0, 1'b0);

    // Bounce on ROTATE
    step(5'b01000, 1'b0);
    step(5'b00000, 1'b0);
    repeat (60) step(5'b01000, 1'b0);
    repeat (40) step(5'b00000, 1'b0);

    // Auto-repeat on DOWN
    repeat (240) step(5'b00100, 1'b0);
    repeat (40) step(5'b00000, 1'b0);

    // Conflict, then LEFT alone
    while (vc != 2) step(5'b0, 1'b0);
    repeat (10) step(5'b00011, 1'b0);
    repeat (12) step(5'b00000, 1'b0);
    repeat (10) step(5'b00010, 1'b0);
    repeat (50) step(5'b00000, 1'b0);

    // START press event landing on the tick cycle
    while (vc != 13) step(5'b0, 1'b0);
    repeat (7) step(5'b10000, 1'b0);
    chk("fb_pre", operation, 5'b00000);
    @(posedge clock); #1;
    chk("fb_op", operation, 5'b10000);
    repeat (40) step(5'b10000, 1'b0);
    repeat (40) step(5'b00000, 1'b0);

    // Reset while RIGHT repeats, button kept held
    repeat (100) step(5'b00001, 1'b0);
    step(5'b00001, 1'b1);
    @(posedge clock); #1;
    chk("mid_rst", operation, 5'b00000);
    repeat (100) step(5'b00001, 1'b0);
    repeat (40) step(5'b00000, 1'b0);

    // Random buttons with bounce and occasional reset
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 39) == 0) cur[b] = ~cur[b];
      step(cur, ($urandom_range(0, 1499) == 0));
    end
    step(5'b0, 1'b0);

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
